// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: digit count, blank codes,
// active-low segment patterns and the edit-mode encodings.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef enum logic [2:0] {
        MODE_RUN = 3'd0,
        MODE_SEC = 3'd1,
        MODE_MIN = 3'd2,
        MODE_HRS = 3'd3
    } mode_e;

    // Digits pair up into fields by idx[2:1]: 0 = seconds, 1 = minutes, 2 = hours.
    function automatic logic field_selected(input logic [2:0] i_mode, input logic [2:0] i_idx);
        logic w_sel;
        case (i_mode)
            MODE_SEC: w_sel = (i_idx[2:1] == 2'd0);
            MODE_MIN: w_sel = (i_idx[2:1] == 2'd1);
            MODE_HRS: w_sel = (i_idx[2:1] == 2'd2);
            default:  w_sel = 1'b0;
        endcase
        return w_sel;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD to active-low 7-segment decoder; values above 9 produce a blank pattern.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans six BCD time digits onto an 8-digit common-anode display with
// separator decimal points and blinking of the field currently being edited.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [3:0] hrstens,
    input  logic [3:0] hrsones,
    input  logic [3:0] mintens,
    input  logic [3:0] minones,
    input  logic [3:0] sectens,
    input  logic [3:0] secones,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC   = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [RW-1:0] r_refresh_cnt;
    logic [2:0]    r_scan_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [2:0]    r_prev_mode;

    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [7:0]    w_an;
    logic          w_dp;
    logic          w_blank;

    always_comb begin
        w_digit = 4'hF;
        w_an    = ANODES_OFF;
        w_dp    = 1'b1;
        case (r_scan_idx)
            3'd0: begin w_digit = secones; w_an = 8'hFE; end
            3'd1: begin w_digit = sectens; w_an = 8'hFD; end
            3'd2: begin w_digit = minones; w_an = 8'hFB; w_dp = 1'b0; end
            3'd3: begin w_digit = mintens; w_an = 8'hF7; end
            3'd4: begin w_digit = hrsones; w_an = 8'hEF; w_dp = 1'b0; end
            3'd5: begin w_digit = hrstens; w_an = 8'hDF; end
            default: begin w_digit = 4'hF; w_an = ANODES_OFF; end
        endcase
    end

    bcd_to_seg u_decode (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Selection follows the registered mode so it stays aligned with the
    // blink state that was cleared on the same edge.
    assign w_blank = r_blink_phase && field_selected(r_prev_mode, r_scan_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= '0;
        end else if (r_refresh_cnt == REFRESH_TC) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= (r_scan_idx == LAST_IDX) ? 3'd0 : r_scan_idx + 3'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_prev_mode   <= 3'd0;
        end else begin
            r_prev_mode <= mode;
            if (mode != r_prev_mode) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (r_blink_cnt == BLINK_TC) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= ANODES_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (w_blank) begin
            an  <= ANODES_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-count reference model pushes
// the expected pins for every clock edge and a monitor compares after the edge.
module tb_seven_seg_scanner;

    localparam int R = 4;
    localparam int B = 32;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic [3:0] hrstens, hrsones, mintens, minones, sectens, secones;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    seven_seg_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .hrstens (hrstens),
        .hrsones (hrsones),
        .mintens (mintens),
        .minones (minones),
        .sectens (sectens),
        .secones (secones),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        int         edge_no;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: k = index of the next clock edge since reset release,
    // e = edge at which the blink timer last restarted, p = mode seen last edge.
    int         k;
    int         e;
    logic [2:0] p;

    logic [6:0] dec_tab [16];
    initial begin
        dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
        dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
        dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'h7F;
    end

    function automatic int idx_at(input int kk);
        return ((kk - 1) / R) % 6;
    endfunction

    function automatic int phase_at(input int kk, input int ee);
        return ((kk - ee) / B) % 2;
    endfunction

    function automatic exp_t model();
        exp_t       x;
        int         idx;
        logic [3:0] d;
        logic [7:0] one_hot;
        bit         sel;
        idx = idx_at(k);
        case (idx)
            0: d = secones;
            1: d = sectens;
            2: d = minones;
            3: d = mintens;
            4: d = hrsones;
            default: d = hrstens;
        endcase
        sel = (p >= 3'd1 && p <= 3'd3) && ((idx / 2) == (int'(p) - 1));
        one_hot   = 8'd1 << idx;
        x.edge_no = k;
        if (sel && phase_at(k, e) == 1) begin
            x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1;
        end else begin
            x.an  = ~one_hot;
            x.seg = dec_tab[d];
            x.dp  = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
        end
        return x;
    endfunction

    // Called at a falling edge: applies current inputs, records the expected
    // pins for the coming rising edge, then advances to the next falling edge.
    task automatic step();
        exp_t x;
        x = model();
        q.push_back(x);
        if (mode != p) e = k + 1;
        p = mode;
        k++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        k = 1;
        e = 1;
        p = 3'd0;
    endtask

    task automatic check_reset_pins(input string nm);
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s: an=%h seg=%h dp=%b, required an=ff seg=7f dp=1", nm, an, seg, dp);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (an !== x.an || seg !== x.seg || dp !== x.dp) begin
                    errors++;
                    $display("FAIL pins@edge%0d: an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                             x.edge_no, an, seg, dp, x.an, x.seg, x.dp);
                end
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        mode = 3'd0;
        hrstens = 4'd1; hrsones = 4'd2; mintens = 4'd3;
        minones = 4'd4; sectens = 4'd5; secones = 4'd6;
        repeat (3) @(negedge clk);
        check_reset_pins("reset_hold");

        // Basic scan from reset release
        rst = 1'b0;
        model_reset();
        repeat (30) step();

        // Full decode range on the seconds-ones digit
        for (int v = 0; v < 16; v++) begin
            secones = 4'(v);
            repeat (24) step();
        end
        secones = 4'd6;

        // Minutes field blinking
        mode = 3'd2;
        repeat (128) step();

        // Switch to hours while the blink phase is on
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (phase_at(k, e) == 1 && p == 3'd2 && idx_at(k) == 2) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL blink_on_wait: phase never reached 1, required within 200 cycles");
        end
        mode = 3'd3;
        repeat (96) step();

        // Out-of-range mode disables blinking
        mode = 3'd5;
        repeat (128) step();

        // Randomised modes and digits
        repeat (800) begin
            if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: secones = 4'($urandom_range(0, 15));
                    1: sectens = 4'($urandom_range(0, 15));
                    2: minones = 4'($urandom_range(0, 15));
                    3: mintens = 4'($urandom_range(0, 15));
                    4: hrsones = 4'($urandom_range(0, 15));
                    default: hrstens = 4'($urandom_range(0, 15));
                endcase
            end
            step();
        end

        // Asynchronous reset in the middle of index 3's dwell
        mode = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (idx_at(k) == 3 && ((k - 1) % R) == 1 && p == 3'd0) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL idx3_wait: index 3 mid-count not reached, required within 100 cycles");
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_pins("async_reset");
        @(negedge clk);
        check_reset_pins("reset_held");
        rst = 1'b0;
        model_reset();
        repeat (30) step();

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
